z80_sound_io: RTL and testbench
===============================

# z80_sound_io

Z80-side I/O port decoder and control for the NeoGeo sound subsystem. It is the Z80 end of the 68k↔Z80 sound command interface. It decodes Z80 IN/OUT cycles into the command-latch read, clear and reply strobes consumed by the 68k-side command latch block. It also generates the Z80 NMI on each new 68k command, holds the four Z80 ROM bank registers and produces the YM2610 chip select.

## Interface
Parameters:
- BANK0_RST, 8'h02, reset value of the $8000–$BFFF bank (16K window)
- BANK1_RST, 8'h06, reset value of the $C000–$DFFF bank (8K window)
- BANK2_RST, 8'h0E, reset value of the $E000–$EFFF bank (4K window)
- BANK3_RST, 8'h1E, reset value of the $F000–$F7FF bank (2K window)

Ports. One clock; reset is synchronous and active-high.
- CLK  in  1  system clock; all Z80 bus inputs are synchronous to it
- RESET  in  1  synchronous, active-high reset
- Z80_ADDR  in  16  Z80 address bus
- nIORQ, nRD, nWR, nM1  in  1 each  Z80 bus controls, active low
- Z80_DIN  in  8  Z80 data out (write data)
- Z80_DOUT  out  8  read data to Z80
- Z80_DOE  out  1  Z80_DOUT valid
- SDD_RD  in  8  68k command byte from the command latch
- SDD_WR  out  8  reply byte to the command latch
- nSDZ80R  out  1  command read strobe, active low
- nSDZ80W  out  1  reply write strobe, active low; the latch captures on its rising edge
- nSDZ80CLR  out  1  command clear strobe, active low
- nSDW  in  1  low while the 68k writes a command
- nNMI  out  1  Z80 NMI, active low
- nYMCS  out  1  YM2610 chip select, active low
- BANK0..BANK3  out  8 each  ROM bank registers

## Operation
- io_rd = ~nIORQ & ~nRD & nM1; io_wr = ~nIORQ & ~nWR & nM1. Interrupt acknowledge (nM1 low) is never decoded.
- Port select = {ADDR[4],ADDR[3],ADDR[2]}:
  - 000 = P_CMD ($00)
  - 001 = P_YM ($04–$07)
  - 010 = P_BNK ($08–$0B)
  - 011 = P_REP ($0C)
  - 110 = P_NMIOFF ($18)
  - Others are ignored, with no side effects.
- Per-access state machine, one per direction: IDLE → START (one cycle, on rising edge of io_rd/io_wr) → ACTIVE (while the access is held) → IDLE.
- Actions in the START cycle:
  - Read P_CMD: clear nmi_pending.
  - Read P_BNK: BANK[ADDR[1:0]] ← ADDR[15:8].
  - Write P_BNK: nmi_en ← 1.
  - Write P_NMIOFF: nmi_en ← 0.
- Strobes, registered, low from the START cycle through the last ACTIVE cycle, high one cycle after io_* falls:
  - nSDZ80R: read P_CMD.
  - nSDZ80W: write P_REP.
  - nSDZ80CLR: write P_CMD.
- SDD_WR ← Z80_DIN on every cycle where io_wr is high and the port is P_REP; otherwise it holds. It therefore holds the final byte when nSDZ80W rises.
- Z80_DOUT = SDD_RD and Z80_DOE = 1 while io_rd is high and the port is P_CMD (combinational). Otherwise Z80_DOE = 0 and Z80_DOUT = 8'hFF.
- nYMCS = ~((io_rd | io_wr) & port == P_YM) (combinational).
- NMI:
  - nmi_pending is set on the falling edge of nSDW, using a registered nSDW_d.
  - nNMI = ~(nmi_pending & nmi_en), registered.
  - Set and clear in the same cycle: set wins.
  - nmi_en going 0→1 with a pending command asserts nNMI on the next cycle.

## Timing
- Reset values:
  - Z80_DOE = 0, Z80_DOUT = 8'hFF.
  - nSDZ80R = nSDZ80W = nSDZ80CLR = 1, nNMI = 1, nYMCS follows its inputs.
  - SDD_WR = 8'h00, BANK0..3 = parameters, nmi_en = 0, nmi_pending = 0.
- During RESET the io_rd_d, io_wr_d and nSDW_d registers load their current inputs. An access or 68k write in progress when RESET falls produces no START, strobe or NMI.
- Latency:
  - Strobes: 1 cycle after the bus edge, in both directions.
  - Bank and NMI-enable update: visible 1 cycle after the rising edge of io_*.
  - nNMI: low 2 cycles after the falling edge of nSDW (edge register, then output register).
- Back-to-back accesses with no idle cycle between them are not possible on a Z80 bus and are not required.
- A minimum one-cycle access still produces a one-cycle strobe.

## Test plan
- NMI: nmi_en set by OUT($08); nSDW low for 4 cycles → nNMI low at +2 cycles. IN($00) with SDD_RD=8'h5A → Z80_DOUT=8'h5A, nSDZ80R low for the access length +0/-0 offset by 1, nNMI high 2 cycles after the read start.
- NMI disabled: after reset, nSDW pulse → nNMI stays high. OUT($08) → nNMI low 2 cycles later. OUT($18) → nNMI high.
- Reply: OUT($0C) with data 8'hA7 → SDD_WR=8'hA7 while nSDZ80W rises. OUT($00) → nSDZ80CLR pulse, nSDZ80W untouched.
- Banks: IN with ADDR=16'h1209, 16'h3A0B → BANK1=8'h12, BANK3=8'h3A. BANK0 and BANK2 keep their reset values 02/0E.
- Edge cases: nSDW falls in the same cycle as an IN($00) START → pending stays set. Interrupt acknowledge (nM1=0, nIORQ=0) → no strobes.
- Reset mid-access: RESET asserted during OUT($0C) and released while io_wr is still high → nSDZ80W stays high and SDD_WR=8'h00.

Source files
------------

// File: rtl/z80_sound_io.sv
// Z80-side I/O decoder for the NeoGeo sound subsystem: command latch strobes,
// command NMI, ROM bank registers and YM2610 chip select.
module z80_sound_io #(
   parameter logic [7:0] BANK0_RST = 8'h02,
   parameter logic [7:0] BANK1_RST = 8'h06,
   parameter logic [7:0] BANK2_RST = 8'h0E,
   parameter logic [7:0] BANK3_RST = 8'h1E
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] Z80_ADDR,
   input  logic        nIORQ,
   input  logic        nRD,
   input  logic        nWR,
   input  logic        nM1,
   input  logic [7:0]  Z80_DIN,
   output logic [7:0]  Z80_DOUT,
   output logic        Z80_DOE,
   input  logic [7:0]  SDD_RD,
   output logic [7:0]  SDD_WR,
   output logic        nSDZ80R,
   output logic        nSDZ80W,
   output logic        nSDZ80CLR,
   input  logic        nSDW,
   output logic        nNMI,
   output logic        nYMCS,
   output logic [7:0]  BANK0,
   output logic [7:0]  BANK1,
   output logic [7:0]  BANK2,
   output logic [7:0]  BANK3
);

   localparam logic [2:0] P_CMD    = 3'b000;
   localparam logic [2:0] P_YM     = 3'b001;
   localparam logic [2:0] P_BNK    = 3'b010;
   localparam logic [2:0] P_REP    = 3'b011;
   localparam logic [2:0] P_NMIOFF = 3'b110;

   // HOLD marks an access already under way when reset released; it is ignored.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      ACTIVE = 2'd2,
      HOLD   = 2'd3
   } acc_state_t;

   acc_state_t rd_state, rd_next, wr_state, wr_next;

   logic       io_rd, io_wr;
   logic [2:0] port;
   logic       rd_start, wr_start, rd_live, wr_live;
   logic       nsdw_d, nsdw_fall;
   logic       nmi_pending, nmi_en;
   logic       unused_bits;

   assign io_rd       = ~nIORQ & ~nRD & nM1;
   assign io_wr       = ~nIORQ & ~nWR & nM1;
   assign port        = Z80_ADDR[4:2];
   assign unused_bits = &{1'b0, Z80_ADDR[7:5]};

   assign rd_start  = (rd_next == START);
   assign wr_start  = (wr_next == START);
   assign rd_live   = (rd_next == START) || (rd_next == ACTIVE);
   assign wr_live   = (wr_next == START) || (wr_next == ACTIVE);
   assign nsdw_fall = nsdw_d & ~nSDW;

   always_comb begin
      rd_next = IDLE;
      if (io_rd) begin
         case (rd_state)
            IDLE:          rd_next = START;
            START, ACTIVE: rd_next = ACTIVE;
            HOLD:          rd_next = HOLD;
            default:       rd_next = IDLE;
         endcase
      end else begin
         rd_next = IDLE;
      end
   end

   always_comb begin
      wr_next = IDLE;
      if (io_wr) begin
         case (wr_state)
            IDLE:          wr_next = START;
            START, ACTIVE: wr_next = ACTIVE;
            HOLD:          wr_next = HOLD;
            default:       wr_next = IDLE;
         endcase
      end else begin
         wr_next = IDLE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rd_state <= io_rd ? HOLD : IDLE;
         wr_state <= io_wr ? HOLD : IDLE;
         nsdw_d   <= nSDW;
      end else begin
         rd_state <= rd_next;
         wr_state <= wr_next;
         nsdw_d   <= nSDW;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         nSDZ80R   <= 1'b1;
         nSDZ80W   <= 1'b1;
         nSDZ80CLR <= 1'b1;
         SDD_WR    <= 8'h00;
      end else begin
         nSDZ80R   <= ~(rd_live && (port == P_CMD));
         nSDZ80W   <= ~(wr_live && (port == P_REP));
         nSDZ80CLR <= ~(wr_live && (port == P_CMD));
         // Follows the bus for the whole write so the latch sees the final byte.
         if (wr_live && (port == P_REP)) begin
            SDD_WR <= Z80_DIN;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         BANK0 <= BANK0_RST;
         BANK1 <= BANK1_RST;
         BANK2 <= BANK2_RST;
         BANK3 <= BANK3_RST;
      end else if (rd_start && (port == P_BNK)) begin
         case (Z80_ADDR[1:0])
            2'd0:    BANK0 <= Z80_ADDR[15:8];
            2'd1:    BANK1 <= Z80_ADDR[15:8];
            2'd2:    BANK2 <= Z80_ADDR[15:8];
            2'd3:    BANK3 <= Z80_ADDR[15:8];
            default: BANK0 <= BANK0;
         endcase
      end
   end

   // A new command (set) takes priority over the Z80 reading the previous one.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         nmi_pending <= 1'b0;
         nmi_en      <= 1'b0;
         nNMI        <= 1'b1;
      end else begin
         if (nsdw_fall) begin
            nmi_pending <= 1'b1;
         end else if (rd_start && (port == P_CMD)) begin
            nmi_pending <= 1'b0;
         end
         if (wr_start && (port == P_BNK)) begin
            nmi_en <= 1'b1;
         end else if (wr_start && (port == P_NMIOFF)) begin
            nmi_en <= 1'b0;
         end
         nNMI <= ~(nmi_pending & nmi_en);
      end
   end

   always_comb begin
      Z80_DOUT = 8'hFF;
      Z80_DOE  = 1'b0;
      if (io_rd && (port == P_CMD) && !RESET) begin
         Z80_DOUT = SDD_RD;
         Z80_DOE  = 1'b1;
      end
   end

   assign nYMCS = ~((io_rd | io_wr) && (port == P_YM));

endmodule

// File: tb/tb_z80_sound_io.sv
// Randomized and directed bench for z80_sound_io; a cycle model predicts every
// output, predictions are queued and a negedge monitor compares them.
module tb_z80_sound_io;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [15:0] Z80_ADDR;
   logic        nIORQ, nRD, nWR, nM1;
   logic [7:0]  Z80_DIN;
   logic [7:0]  Z80_DOUT;
   logic        Z80_DOE;
   logic [7:0]  SDD_RD;
   logic [7:0]  SDD_WR;
   logic        nSDZ80R, nSDZ80W, nSDZ80CLR;
   logic        nSDW;
   logic        nNMI, nYMCS;
   logic [7:0]  BANK0, BANK1, BANK2, BANK3;

   always #5 CLK = ~CLK;

   z80_sound_io dut (
      .CLK(CLK), .RESET(RESET), .Z80_ADDR(Z80_ADDR),
      .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
      .Z80_DIN(Z80_DIN), .Z80_DOUT(Z80_DOUT), .Z80_DOE(Z80_DOE),
      .SDD_RD(SDD_RD), .SDD_WR(SDD_WR),
      .nSDZ80R(nSDZ80R), .nSDZ80W(nSDZ80W), .nSDZ80CLR(nSDZ80CLR),
      .nSDW(nSDW), .nNMI(nNMI), .nYMCS(nYMCS),
      .BANK0(BANK0), .BANK1(BANK1), .BANK2(BANK2), .BANK3(BANK3)
   );

   typedef struct packed {
      logic [7:0]  dout;
      logic        doe;
      logic        ymcs;
      logic        sr;
      logic        sw;
      logic        sclr;
      logic        nmi;
      logic [7:0]  sddwr;
      logic [31:0] banks;
   } exp_t;

   exp_t expq[$];
   int   errors = 0;
   int   checks = 0;

   // Stimulus shadows, applied to the DUT one tick after each rising edge.
   logic        t_rst = 1'b1;
   logic [15:0] t_addr = 16'h0000;
   logic        t_iorq = 1'b1, t_rd = 1'b1, t_wr = 1'b1, t_m1 = 1'b1;
   logic [7:0]  t_din = 8'h00, t_sdd = 8'h00;
   logic        t_sdw = 1'b1;

   // Model state: what the outputs will be after the next edge.
   logic        m_prev_rd = 1'b0, m_prev_wr = 1'b0, m_prev_sdw = 1'b1;
   logic        m_rd_live = 1'b0, m_wr_live = 1'b0;
   logic        m_pending = 1'b0, m_en = 1'b0, m_nmi = 1'b1;
   logic        m_sr = 1'b1, m_sw = 1'b1, m_sclr = 1'b1;
   logic [7:0]  m_sddwr = 8'h00;
   logic [7:0]  m_bank[4] = '{8'h02, 8'h06, 8'h0E, 8'h1E};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic cyc();
      exp_t e;
      logic rd, wr, rd_go, wr_go;
      logic [2:0] sel;
      @(posedge CLK);
      #1;
      RESET = t_rst; Z80_ADDR = t_addr; nIORQ = t_iorq; nRD = t_rd; nWR = t_wr;
      nM1 = t_m1; Z80_DIN = t_din; SDD_RD = t_sdd; nSDW = t_sdw;
      rd  = ~t_iorq & ~t_rd & t_m1;
      wr  = ~t_iorq & ~t_wr & t_m1;
      sel = t_addr[4:2];
      e.doe   = ~t_rst & rd & (sel == 3'd0);
      e.dout  = e.doe ? t_sdd : 8'hFF;
      e.ymcs  = ~((rd | wr) & (sel == 3'd1));
      e.sr    = m_sr;
      e.sw    = m_sw;
      e.sclr  = m_sclr;
      e.nmi   = m_nmi;
      e.sddwr = m_sddwr;
      e.banks = {m_bank[3], m_bank[2], m_bank[1], m_bank[0]};
      expq.push_back(e);
      if (t_rst) begin
         m_rd_live = 1'b0; m_wr_live = 1'b0;
         m_pending = 1'b0; m_en = 1'b0; m_nmi = 1'b1;
         m_sr = 1'b1; m_sw = 1'b1; m_sclr = 1'b1; m_sddwr = 8'h00;
         m_bank = '{8'h02, 8'h06, 8'h0E, 8'h1E};
      end else begin
         rd_go = rd & ~m_prev_rd;
         wr_go = wr & ~m_prev_wr;
         if (rd_go) m_rd_live = 1'b1;
         if (!rd)   m_rd_live = 1'b0;
         if (wr_go) m_wr_live = 1'b1;
         if (!wr)   m_wr_live = 1'b0;
         m_sr   = ~(rd & m_rd_live & (sel == 3'd0));
         m_sw   = ~(wr & m_wr_live & (sel == 3'd3));
         m_sclr = ~(wr & m_wr_live & (sel == 3'd0));
         if (wr & m_wr_live & (sel == 3'd3)) m_sddwr = t_din;
         if (rd_go & (sel == 3'd2)) m_bank[t_addr[1:0]] = t_addr[15:8];
         m_nmi = ~(m_pending & m_en);
         if (wr_go & (sel == 3'd2)) m_en = 1'b1;
         if (wr_go & (sel == 3'd6)) m_en = 1'b0;
         if (m_prev_sdw & ~t_sdw) m_pending = 1'b1;
         else if (rd_go & (sel == 3'd0)) m_pending = 1'b0;
      end
      m_prev_rd = rd; m_prev_wr = wr; m_prev_sdw = t_sdw;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic access(input bit is_wr, input logic [15:0] a, input logic [7:0] d, input int len);
      t_addr = a; t_din = d; t_iorq = 1'b0;
      if (is_wr) t_wr = 1'b0;
      else       t_rd = 1'b0;
      repeat (len) cyc();
      t_iorq = 1'b1; t_rd = 1'b1; t_wr = 1'b1;
      cyc();
   endtask

   // Monitor: every sampled cycle is checked against its queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("dout",  {24'h0, Z80_DOUT}, {24'h0, e.dout});
            chk("doe",   {31'h0, Z80_DOE}, {31'h0, e.doe});
            chk("ymcs",  {31'h0, nYMCS}, {31'h0, e.ymcs});
            chk("sdz80r", {31'h0, nSDZ80R}, {31'h0, e.sr});
            chk("sdz80w", {31'h0, nSDZ80W}, {31'h0, e.sw});
            chk("sdz80clr", {31'h0, nSDZ80CLR}, {31'h0, e.sclr});
            chk("nmi",   {31'h0, nNMI}, {31'h0, e.nmi});
            chk("sdd_wr", {24'h0, SDD_WR}, {24'h0, e.sddwr});
            chk("banks", {BANK3, BANK2, BANK1, BANK0}, e.banks);
         end
      end
   end

   initial begin
      RESET = 1'b1; Z80_ADDR = 16'h0000; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
      nM1 = 1'b1; Z80_DIN = 8'h00; SDD_RD = 8'h00; nSDW = 1'b1;
      idle(3);
      t_rst = 1'b0;
      idle(2);
      // command with NMI disabled, then enable / disable
      t_sdw = 1'b0; idle(3); t_sdw = 1'b1; idle(3);
      access(1'b1, 16'h0008, 8'h00, 2); idle(3);
      access(1'b1, 16'h0018, 8'h00, 2); idle(2);
      // enabled NMI, then command read clears it
      access(1'b1, 16'h0008, 8'h00, 1);
      t_sdw = 1'b0; idle(4); t_sdw = 1'b1; idle(3);
      t_sdd = 8'h5A;
      access(1'b0, 16'h0000, 8'h00, 3); idle(3);
      // reply and clear
      access(1'b1, 16'h000C, 8'hA7, 3); idle(1);
      access(1'b1, 16'h0000, 8'h00, 2); idle(1);
      // banks
      access(1'b0, 16'h1209, 8'h00, 2);
      access(1'b0, 16'h3A0B, 8'h00, 1); idle(1);
      // new command in the same cycle as a command read start
      t_sdw = 1'b0; access(1'b0, 16'h0000, 8'h00, 2); t_sdw = 1'b1; idle(3);
      // interrupt acknowledge cycles
      t_m1 = 1'b0;
      access(1'b0, 16'h0000, 8'h00, 2);
      access(1'b1, 16'h000C, 8'h33, 2);
      t_m1 = 1'b1;
      // YM chip select
      access(1'b1, 16'h0005, 8'h11, 2);
      access(1'b0, 16'h0006, 8'h00, 1);
      // reset in the middle of a reply write
      t_addr = 16'h000C; t_din = 8'h5C; t_iorq = 1'b0; t_wr = 1'b0;
      idle(2);
      t_rst = 1'b1; idle(2); t_rst = 1'b0; idle(2);
      t_iorq = 1'b1; t_wr = 1'b1; idle(2);
      // randomized traffic
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 2) == 0) t_sdw = ~t_sdw;
         t_m1  = ($urandom_range(0, 7) != 0);
         t_sdd = 8'($urandom);
         access(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                $urandom_range(1, 4));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         if ($urandom_range(0, 49) == 0) begin
            t_rst = 1'b1; idle(1); t_rst = 1'b0;
         end
      end
      t_m1 = 1'b1; t_sdw = 1'b1; idle(2);
      for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge CLK);
      #1;
      if (expq.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d predictions left, expected 0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
